// File: rtl/cpu5_mc_ctrl_pkg.sv
// Shared constants and types for the cpu5 multicycle control unit:
// state codes, opcode/funct3 encodings, datapath mux selects and ALU codes.
package cpu5_mc_ctrl_pkg;

    localparam int ALU_CTRL_W = 3;

    // Fixed codes so the debug state output is stable across rebuilds
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_ERROR    = 4'd15
    } state_t;

    // Opcodes of the supported RV32I subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // Datapath mux selects
    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALUOUT  = 1'b1;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALUY    = 2'b10;

    // ALU operation codes driven towards the ALU
    localparam logic [2:0] CPU5_ALU_CONTROL_ADD = 3'b010;
    localparam logic [2:0] CPU5_ALU_CONTROL_SUB = 3'b110;

    // Coarse ALU request from the FSM; the decoder refines FUNCT using funct7b5
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Legality check done in DECODE: picks the first execution state,
    // or ERROR for any encoding outside the supported subset
    function automatic state_t decode_next(input logic [6:0] opcode,
                                           input logic [2:0] funct3);
        state_t nxt;
        nxt = S_ERROR;
        if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == F3_WORD)
            nxt = S_MEMADR;
        else if (opcode == OP_RTYPE && funct3 == F3_ADD)
            nxt = S_EXECR;
        else if (opcode == OP_IMM && funct3 == F3_ADD)
            nxt = S_EXECI;
        else if (opcode == OP_BRANCH && funct3 == F3_BEQ)
            nxt = S_BEQ;
        return nxt;
    endfunction

endpackage

// File: rtl/cpu5_mc_ctrl_alu_dec.sv
// ALU decoder: turns the FSM's coarse alu_op plus funct7b5 into alu_control.
module cpu5_alu_dec
    import cpu5_mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [1:0]            i_alu_op,
    input  logic                  i_funct7b5,
    output logic [ALU_CTRL_W-1:0] o_alu_control
);

    // Add by default; R-type selects sub through instr[30]
    always_comb begin
        o_alu_control = ALU_CTRL_W'(CPU5_ALU_CONTROL_ADD);
        case (i_alu_op)
            ALUOP_SUB:   o_alu_control = ALU_CTRL_W'(CPU5_ALU_CONTROL_SUB);
            ALUOP_FUNCT: o_alu_control = i_funct7b5 ? ALU_CTRL_W'(CPU5_ALU_CONTROL_SUB)
                                                    : ALU_CTRL_W'(CPU5_ALU_CONTROL_ADD);
            default:     o_alu_control = ALU_CTRL_W'(CPU5_ALU_CONTROL_ADD);
        endcase
    end

endmodule

// File: rtl/cpu5_mc_ctrl.sv
// Multicycle control FSM for the cpu5 datapath (lw, sw, add, sub, addi, beq)
// with a req/ready handshake towards a variable-latency unified memory.
module cpu5_mc_ctrl
    import cpu5_mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    input  logic                  i_zero,
    input  logic                  i_mem_ready,
    output logic                  o_mem_req,
    output logic                  o_mem_write,
    output logic                  o_adr_src,
    output logic                  o_ir_write,
    output logic                  o_pc_write,
    output logic                  o_reg_write,
    output logic [1:0]            o_alu_src_a,
    output logic [1:0]            o_alu_src_b,
    output logic [1:0]            o_result_src,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic                  o_illegal_instr,
    output logic [3:0]            o_state
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_alu_op;

    // State register; a low resetn at the edge returns to FETCH
    always_ff @(posedge i_clk) begin
        if (!i_resetn)
            r_state <= S_FETCH;
        else
            r_state <= w_next_state;
    end

    // Next state and per-state controls; memory states hold until mem_ready
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_alu_op     = ALUOP_ADD;
        o_adr_src    = ADR_PC;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RS2;
        o_result_src = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                o_adr_src    = ADR_PC;
                o_alu_src_a  = SRCA_PC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALUY;
                if (i_mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                o_alu_src_a  = SRCA_OLDPC;
                o_alu_src_b  = SRCB_IMM;
                w_next_state = decode_next(i_opcode, i_funct3);
            end
            S_MEMADR: begin
                o_alu_src_a  = SRCA_RS1;
                o_alu_src_b  = SRCB_IMM;
                w_next_state = i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                o_adr_src = ADR_ALUOUT;
                if (i_mem_ready)
                    w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                o_result_src = RES_MEMDATA;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                o_adr_src   = ADR_ALUOUT;
                if (i_mem_ready)
                    w_next_state = S_FETCH;
            end
            S_EXECR: begin
                o_alu_src_a  = SRCA_RS1;
                o_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                o_alu_src_a  = SRCA_RS1;
                o_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALUOP_ADD;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                o_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                o_alu_src_a  = SRCA_RS1;
                o_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                o_result_src = RES_ALUOUT;
                w_pc_write   = i_zero;
                w_next_state = S_FETCH;
            end
            S_ERROR: begin
                w_illegal    = 1'b1;
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_state = S_ERROR;
            end
        endcase
    end

    // Enables and the error flag are suppressed for as long as resetn is low
    assign o_mem_req       = w_mem_req   & i_resetn;
    assign o_mem_write     = w_mem_write & i_resetn;
    assign o_ir_write      = w_ir_write  & i_resetn;
    assign o_pc_write      = w_pc_write  & i_resetn;
    assign o_reg_write     = w_reg_write & i_resetn;
    assign o_illegal_instr = w_illegal   & i_resetn;
    assign o_state         = r_state;

    cpu5_alu_dec #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct7b5    (i_funct7b5),
        .o_alu_control (o_alu_control)
    );

endmodule

// File: tb/tb_cpu5_mc_ctrl.sv
// Self-checking bench for cpu5_mc_ctrl: directed cases plus a randomized
// instruction stream, compared cycle by cycle against an instruction-level model.
module tb_cpu5_mc_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [1:0] resSrc;
        logic [2:0] aluCtl;
        logic       illegal;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;
    logic       memReq;
    logic       memWrite;
    logic       adrSrc;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
    logic       illegalInstr;
    logic [3:0] stateO;

    int checks = 0;
    int errors = 0;

    cpu5_mc_ctrl #(
        .ALU_CTRL_W (3)
    ) dut (
        .i_clk           (clk),
        .i_resetn        (resetn),
        .i_opcode        (opcode),
        .i_funct3        (funct3),
        .i_funct7b5      (funct7b5),
        .i_zero          (zero),
        .i_mem_ready     (memReady),
        .o_mem_req       (memReq),
        .o_mem_write     (memWrite),
        .o_adr_src       (adrSrc),
        .o_ir_write      (irWrite),
        .o_pc_write      (pcWrite),
        .o_reg_write     (regWrite),
        .o_alu_src_a     (aluSrcA),
        .o_alu_src_b     (aluSrcB),
        .o_result_src    (resultSrc),
        .o_alu_control   (aluControl),
        .o_illegal_instr (illegalInstr),
        .o_state         (stateO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] st, input logic rq, input logic wr,
                                input logic adr, input logic irw, input logic pcw,
                                input logic rw, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] r, input logic [2:0] alu, input logic ill);
        exp_t e;
        e = {st, rq, wr, adr, irw, pcw, rw, a, b, r, alu, ill};
        return e;
    endfunction

    // Expected outputs while resetn is low (register sits in FETCH, enables off)
    function automatic exp_t resetExp();
        return mk(4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b010, 0);
    endfunction

    task automatic checkOutput(input string tag, input exp_t expv);
        exp_t obs;
        obs = {stateO, memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
               aluSrcA, aluSrcB, resultSrc, aluControl, illegalInstr};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs, check just after they settle, advance past the edge
    task automatic applyStimulus(input logic ready, input string tag, input exp_t expv);
        memReady = ready;
        #1;
        checkOutput(tag, expv);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int cycles);
        resetn = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset", resetExp());
        end
        resetn = 1'b1;
    endtask

    task automatic loadInstr(input logic [31:0] instr);
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        funct7b5 = instr[30];
    endtask

    // Instruction-level model: classify the word, then walk its expected
    // cycle schedule (fetch with waits, decode, class-specific phases)
    task automatic runInstr(input logic [31:0] instr, input int fetchWait,
                            input int memWait, input logic z, input string name);
        int kind;
        logic [2:0] rAlu;
        if (instr[6:0] == 7'b0000011 && instr[14:12] == 3'b010)      kind = 0;
        else if (instr[6:0] == 7'b0100011 && instr[14:12] == 3'b010) kind = 1;
        else if (instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000) kind = 2;
        else if (instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000) kind = 3;
        else if (instr[6:0] == 7'b1100011 && instr[14:12] == 3'b000) kind = 4;
        else                                                         kind = 5;
        loadInstr(instr);
        zero = z;
        for (int i = 0; i < fetchWait; i++)
            applyStimulus(0, $sformatf("%s fetch-wait", name),
                          mk(4'd0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b010, 0));
        applyStimulus(1, $sformatf("%s fetch", name),
                      mk(4'd0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b010, 0));
        applyStimulus(1'($urandom_range(0, 1)), $sformatf("%s decode", name),
                      mk(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 0));
        case (kind)
            0, 1: begin
                applyStimulus(1'($urandom_range(0, 1)), $sformatf("%s memadr", name),
                              mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b010, 0));
                for (int i = 0; i <= memWait; i++)
                    applyStimulus((i == memWait), $sformatf("%s mem", name),
                                  mk((kind == 0) ? 4'd3 : 4'd5, 1, (kind == 1), 1,
                                     0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b010, 0));
                if (kind == 0)
                    applyStimulus(1'($urandom_range(0, 1)), $sformatf("%s memwb", name),
                                  mk(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b010, 0));
            end
            2, 3: begin
                rAlu = (kind == 2 && instr[30]) ? 3'b110 : 3'b010;
                applyStimulus(1'($urandom_range(0, 1)), $sformatf("%s exec", name),
                              mk((kind == 2) ? 4'd6 : 4'd7, 0, 0, 0, 0, 0, 0, 2'b10,
                                 (kind == 2) ? 2'b00 : 2'b01, 2'b00, rAlu, 0));
                applyStimulus(1'($urandom_range(0, 1)), $sformatf("%s aluwb", name),
                              mk(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b010, 0));
            end
            4: begin
                applyStimulus(1'($urandom_range(0, 1)), $sformatf("%s beq", name),
                              mk(4'd9, 0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 3'b110, 0));
            end
            default: begin
                for (int i = 0; i < 12; i++)
                    applyStimulus(1'($urandom_range(0, 1)), $sformatf("%s error", name),
                                  mk(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b010, 1));
            end
        endcase
    endtask

    function automatic logic [31:0] randInstr();
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 4))
            0:       return {imm, rs1, 3'b010, rd, 7'b0000011};
            1:       return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            2:       return {1'b0, 1'($urandom_range(0, 1)), 5'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
            3:       return {imm, rs1, 3'b000, rd, 7'b0010011};
            default: return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
        endcase
    endfunction

    // Hard stop in case the sequence ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn   = 1'b0;
        opcode   = 7'b0;
        funct3   = 3'b0;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        memReady = 1'b1;

        $display("[TB] reset, then add/sub");
        doReset(2);
        runInstr(32'h002081B3, 0, 0, 0, "add");
        runInstr(32'h402081B3, 0, 0, 0, "sub");

        $display("[TB] lw with memory wait states");
        runInstr(32'h0000A183, 2, 3, 0, "lw");

        $display("[TB] beq taken and not taken");
        runInstr(32'h00208463, 0, 0, 1, "beqTaken");
        runInstr(32'h00208463, 0, 0, 0, "beqNotTaken");
        runInstr(32'h0020A023, 1, 0, 0, "sw");

        $display("[TB] sw interrupted by reset during MEMWRITE");
        loadInstr(32'h0020A023);
        applyStimulus(1, "swR fetch", mk(4'd0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b010, 0));
        applyStimulus(0, "swR decode", mk(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 0));
        applyStimulus(0, "swR memadr", mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b010, 0));
        applyStimulus(0, "swR memwrite-wait", mk(4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b010, 0));
        memReady = 1'b1;
        resetn   = 1'b0;
        #1;
        checkOutput("swR reset-same-cycle", mk(4'd5, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b010, 0));
        @(posedge clk);
        #1;
        checkOutput("swR after-edge", resetExp());
        resetn = 1'b1;
        runInstr(32'h002081B3, 0, 0, 0, "addAfterReset");

        $display("[TB] illegal encodings");
        runInstr(32'h0000007F, 0, 0, 0, "illegalOpcode");
        doReset(1);
        runInstr(32'h00008183, 0, 0, 0, "lwBadFunct3");
        doReset(1);

        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 40; n++)
            runInstr(randInstr(), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $sformatf("rand%0d", n));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
